// File: rtl/nv_blkbox_skid_pipe.sv
// Two-entry registered valid/ready skid stage ahead of a black-box buffer cell.
// Optional saturating stall counter enabled by NV_BLKBOX_SKID_PIPE_STALL_CNT_EN.
module nv_blkbox_skid_pipe #(
  parameter int DW          = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rst,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [DW-1:0]          in_pd,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [DW-1:0]          out_pd,
  output logic [1:0]             occ
`ifdef NV_BLKBOX_SKID_PIPE_STALL_CNT_EN
  ,
  input  logic                   stall_cnt_clr,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  // Handshakes: a beat moves on a port in any cycle where its valid and ready
  // are both high at the rising edge; the sender holds valid and payload
  // until accepted, and ready never depends combinationally on the far side.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   m_q, m_d;
  logic [DW-1:0]   s_q, s_d;

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q <= ST_EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_vld) begin
          state_d = ST_ONE;
          m_d     = in_pd;
        end
      end
      ST_ONE: begin
        if (in_vld && out_rdy) begin
          m_d = in_pd;
        end else if (in_vld) begin
          state_d = ST_TWO;
          s_d     = in_pd;
        end else if (out_rdy) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_rdy is low here, so in_vld is ignored
        if (out_rdy) begin
          state_d = ST_ONE;
          m_d     = s_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign out_vld = (state_q != ST_EMPTY);
  assign in_rdy  = (state_q != ST_TWO);
  assign occ     = state_q;
  assign out_pd  = m_q;

`ifdef NV_BLKBOX_SKID_PIPE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic                   stall;

  assign stall = out_vld && !out_rdy;

  // Clear wins over a coincident stall; count saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_cnt_clr) begin
      cnt_d = '0;
    end else if (stall && (cnt_q != {STALL_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;
`endif

endmodule

// File: doc/nv_blkbox_skid_pipe.md
Name: nv_blkbox_skid_pipe

Overview:
- Two-entry registered valid/ready skid stage that retimes a payload bus before it enters a black-box buffer cell on long or partition-crossing routes.
- Breaks timing on the data/valid path and the ready path: `in_rdy` depends only on local state, never combinationally on `out_rdy`.
- Sits directly upstream of the black-box buffer, which consumes `out_pd`/`out_vld`.

Parameters:
- DW, 32, payload width in bits (1..1024).
- STALL_CNT_W, 16, stall counter width (used only with the optional feature).

Ports:
- nvdla_core_clk  input  1  core clock; all state updates on rising edge.
- nvdla_core_rst  input  1  reset, asynchronous, active-high.
- in_vld  input  1  upstream payload valid.
- in_rdy  output  1  stage can accept; registered-state derived.
- in_pd  input  DW  upstream payload.
- out_vld  output  1  payload available to downstream.
- out_rdy  input  1  downstream accepts.
- out_pd  output  DW  payload to downstream (main register).
- occ  output  2  entries held: 0, 1 or 2.
- stall_cnt_clr  input  1  synchronous clear of stall counter (optional feature only).
- stall_cnt  output  STALL_CNT_W  saturating stall count (optional feature only).

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high on nvdla_core_rst.
- Storage: main register M (drives `out_pd`) and skid register S.
- State machine: EMPTY(occ=0), ONE(occ=1), TWO(occ=2).
- Outputs from state:
  - `out_vld` = (state != EMPTY).
  - `in_rdy` = (state != TWO).
  - `occ` = state encoding.
- Handshakes: input handshake = `in_vld & in_rdy`; output handshake = `out_vld & out_rdy`.
- Transitions:
  - EMPTY: in_vld → ONE, M<=in_pd; else stay.
  - ONE, in_vld & out_rdy → ONE, M<=in_pd (simultaneous push/pop, full throughput).
  - ONE, in_vld & !out_rdy → TWO, S<=in_pd, M unchanged.
  - ONE, !in_vld & out_rdy → EMPTY.
  - ONE, !in_vld & !out_rdy → stay, M held.
  - TWO, out_rdy → ONE, M<=S.
  - TWO, !out_rdy → stay. `in_vld` ignored because `in_rdy`=0.
- Latency and throughput: input handshake in cycle N → `out_vld`=1 with that payload in cycle N+1. Sustained throughput 1/clk when `out_rdy`=1.
- Ordering: strict FIFO; no payload dropped or duplicated.
- `out_pd` stability: holds stable while `out_vld` & !out_rdy. M is only written in EMPTY, on an output handshake, or on TWO→ONE.
- `in_vld` low: `in_pd` is don't-care and is not captured.
- Reset (any time, including mid-transfer, asynchronous):
  - State→EMPTY, M=0, S=0, stall counter=0.
  - Therefore `out_vld`=0, `out_pd`=0, `in_rdy`=1, `occ`=0.
  - In-flight entries are discarded.
  - First capture occurs on the first rising edge after reset deasserts.
- Protocol violation (in_vld asserted while in_rdy=0): no state change, `in_pd` dropped. Upstream must hold valid/payload until accepted.

Optional Feature:
- Macro: NV_BLKBOX_SKID_PIPE_STALL_CNT_EN.
- With macro defined:
  - Ports `stall_cnt_clr` and `stall_cnt` exist.
  - Counter increments each cycle `out_vld` & !out_rdy and saturates at all-ones.
  - `stall_cnt_clr` has priority: counter=0 next cycle even if a stall occurs that cycle.
  - Reset value 0.
- Without macro: both ports and the counter are absent. Datapath behaviour is identical.

Test Plan:
- Reset mid-stream: hold state TWO with payloads 0xA5, 0x5A, assert rst asynchronously mid-cycle → `out_vld`=0, `out_pd`=0, `in_rdy`=1, `occ`=0 immediately; after deassert, push 0x11 → `out_pd`=0x11 next cycle.
- Full throughput: `out_rdy`=1, push 0..99 back-to-back → outputs 0..99 in order, one per cycle, first at 1-cycle latency, `occ` stays 1.
- Skid fill: in ONE holding 0x1, push 0x2 with `out_rdy`=0 → `occ`=2, `in_rdy`=0, `out_pd`=0x1 stable; raise `out_rdy` → 0x1 then 0x2 delivered, `in_rdy` returns 1 after the first pop.
- Random backpressure: 10k cycles, random `in_vld`/`out_rdy` at 50% → scoreboard shows in-order, no loss/duplication; `in_rdy` never depends on `out_rdy` in the same cycle.
- Drain to empty: in ONE, `in_vld`=0, `out_rdy`=1 → EMPTY next cycle, `out_vld`=0, `out_pd` retains last value.
- Stall counter (macro on, STALL_CNT_W=4): hold `out_vld`=1/`out_rdy`=0 for 20 cycles → `stall_cnt`=15 (saturated); pulse `stall_cnt_clr` during a stall → `stall_cnt`=0 next cycle, then 1.
